bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Clr, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port En, input, 1 bit: count enable.
REQ-005 The block SHALL have port Up, input, 1 bit: direction, 1 = increment and 0 = decrement.
REQ-006 The block SHALL have port Load, input, 1 bit: parallel-load strobe.
REQ-007 The block SHALL have port LoadVal, input, 4*DIGITS bits: BCD load value, digit 0 in bits [3:0].
REQ-008 The block SHALL have port Count, output, 4*DIGITS bits: current BCD count, registered.
REQ-009 The block SHALL have port HEX, output, 7*DIGITS bits: active-low 7-segment, digit k in bits [7k+6:7k], bit 0 = segment a through bit 6 = segment g.
REQ-010 The block SHALL have port Tc, output, 1 bit: terminal count, combinational.
REQ-011 The block SHALL have port Wrap, output, 1 bit: registered one-cycle pulse after a wrap-around.
REQ-012 The block SHALL have port LoadErr, output, 1 bit: registered one-cycle pulse after a rejected load.

Function
REQ-013 Per-edge priority SHALL be Clr, then Load, then En; with none of them asserted, Count SHALL hold.
REQ-014 Load with every LoadVal nibble <= 9 SHALL set Count = LoadVal on the next edge, regardless of En.
REQ-015 Load with any LoadVal nibble > 9 SHALL leave Count unchanged and SHALL pulse LoadErr high for exactly the following cycle.
REQ-016 En with Up = 1 SHALL increment Count as a decimal ripple: digit k increments only when digits 0..k-1 are all 9, and any digit stepping past 9 becomes 0.
REQ-017 En with Up = 0 SHALL decrement Count: digit k decrements only when digits 0..k-1 are all 0, and any digit stepping below 0 becomes 9.
REQ-018 Incrementing from the all-9 value SHALL wrap Count to 0; decrementing from 0 SHALL wrap Count to the all-9 value.
REQ-019 Either wrap SHALL pulse Wrap high for exactly the cycle after the wrapping edge.
REQ-020 Tc SHALL equal En & ~Load & ((Up & Count = all-9) | (~Up & Count = 0)); Tc SHALL be 0 while Clr = 1.
REQ-021 HEX SHALL be a registered decode of Count, lagging Count by exactly one clock.
REQ-022 The active-low decode SHALL be 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-023 A Count nibble > 9 is unreachable; if one ever occurs, its HEX digit SHALL be 0x7F (blank).
REQ-024 Load asserted at the same edge as a would-be wrap SHALL take the load and SHALL NOT pulse Wrap.
REQ-025 Toggling Up while En is held SHALL take effect on the very next edge, with no extra cycle and no skipped value.
REQ-026 Wrap and LoadErr SHALL never be high in the same cycle.

Reset
REQ-027 While Clr = 1 at a rising edge, the next state SHALL be Count = 0, every HEX digit = 0x40, Wrap = 0 and LoadErr = 0.
REQ-028 Clr asserted mid-count or coincident with Load, En or a wrap SHALL override all of them, and no Wrap or LoadErr pulse SHALL follow.
REQ-029 The first edge after Clr deasserts SHALL obey REQ-013 normally.

Verification
REQ-030 DIGITS=2, Clr 1 cycle, then En=1, Up=1 for 100 edges -> Count runs 00..99 then back to 00; Wrap high exactly once, in the cycle after the 99->00 edge; Tc high only while Count=99.
REQ-031 DIGITS=2, Count=10, En=1, Up=0 for 11 edges -> Count runs 09,08..00,99; Wrap pulses once after the 00->99 edge.
REQ-032 DIGITS=2, Load with LoadVal=0x47 -> Count=0x47 after 1 edge and HEX=0x19,0x78 one edge later; then Load with LoadVal=0x4A -> Count stays 0x47 and LoadErr pulses for 1 cycle.
REQ-033 DIGITS=3, Count=999, En=1, Up=1, Load=1 with LoadVal=0x123 on the same edge -> Count=0x123 and no Wrap pulse.
REQ-034 DIGITS=2, Count=0x58, En=1, Clr raised for 1 edge -> Count=00 and HEX=0x40,0x40 on that edge; counting resumes at 01 on the next edge.
REQ-035 DIGITS=4, En=1 while Up alternates every edge starting from 0x0999 -> Count alternates 1000/0999 with no Wrap pulses.

Source files
------------

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// =============================================================================
// bcd_updown_counter : DIGITS-wide BCD up/down counter with parallel load,
//                      terminal count, wrap/load-error pulses and 7-seg decode.
// Revision: 1.0
// =============================================================================
module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  output logic [4*DIGITS-1:0]   Count,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  Tc,
  output logic                  Wrap,
  output logic                  LoadErr
);

  localparam logic [6:0] c_seg_zero  = 7'h40;
  localparam logic [6:0] c_seg_blank = 7'h7F;

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] step_val;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                wrap_q, wrap_d;
  logic                lerr_q, lerr_d;
  logic                all9, all0, load_ok;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return c_seg_zero;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return c_seg_blank;
    endcase
  endfunction

  // Ripple step: all9/all0 hold "every lower digit is 9/0" while walking up
  // the digits, and end up describing the whole count after the loop.
  always_comb begin : step_logic
    logic [3:0] dig;
    dig      = 4'd0;
    step_val = count_q;
    all9     = 1'b1;
    all0     = 1'b1;
    load_ok  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      dig = count_q[4*k +: 4];
      if (Up) begin
        if (all9) begin
          step_val[4*k +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
        end
      end else if (all0) begin
        step_val[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      all9    = all9 & (dig == 4'd9);
      all0    = all0 & (dig == 4'd0);
      load_ok = load_ok & (LoadVal[4*k +: 4] <= 4'd9);
    end
  end

  assign Tc = En & ~Load & ~Clr & ((Up & all9) | (~Up & all0));

  always_comb begin : next_state
    count_d = count_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (Load) begin
      if (load_ok) begin
        count_d = LoadVal;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (En) begin
      count_d = step_val;
      wrap_d  = Up ? all9 : all0;
    end
  end

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign hex_d[7*k +: 7] = seg_decode(count_q[4*k +: 4]);
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Clr) begin
      count_q <= '0;
      hex_q   <= {DIGITS{c_seg_zero}};
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      hex_q   <= hex_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign Count   = count_q;
  assign HEX     = hex_q;
  assign Wrap    = wrap_q;
  assign LoadErr = lerr_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// Bench for bcd_updown_counter: three instances (2, 3, 4 digits) share one
// stimulus stream and are compared against a decimal-arithmetic reference model.
module tb_bcd_updown_counter;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        En = 1'b0;
  logic        Up = 1'b0;
  logic        Load = 1'b0;
  logic [31:0] LoadVal = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  cnt2;  logic [13:0] hex2;  logic tc2, wrap2, lerr2;
  logic [11:0] cnt3;  logic [20:0] hex3;  logic tc3, wrap3, lerr3;
  logic [15:0] cnt4;  logic [27:0] hex4;  logic tc4, wrap4, lerr4;

  bcd_updown_counter #(.DIGITS(2)) u_dut2 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[7:0]),
    .Count(cnt2), .HEX(hex2), .Tc(tc2), .Wrap(wrap2), .LoadErr(lerr2));
  bcd_updown_counter #(.DIGITS(3)) u_dut3 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[11:0]),
    .Count(cnt3), .HEX(hex3), .Tc(tc3), .Wrap(wrap3), .LoadErr(lerr3));
  bcd_updown_counter #(.DIGITS(4)) u_dut4 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[15:0]),
    .Count(cnt4), .HEX(hex4), .Tc(tc4), .Wrap(wrap4), .LoadErr(lerr4));

  always #5 Clk = ~Clk;

  logic [31:0] o_cnt  [3];
  logic [27:0] o_hex  [3];
  logic        o_tc   [3];
  logic        o_wrap [3];
  logic        o_lerr [3];

  assign o_cnt[0] = 32'(cnt2);  assign o_hex[0] = 28'(hex2);
  assign o_cnt[1] = 32'(cnt3);  assign o_hex[1] = 28'(hex3);
  assign o_cnt[2] = 32'(cnt4);  assign o_hex[2] = hex4;
  assign o_tc[0] = tc2;  assign o_wrap[0] = wrap2;  assign o_lerr[0] = lerr2;
  assign o_tc[1] = tc3;  assign o_wrap[1] = wrap3;  assign o_lerr[1] = lerr3;
  assign o_tc[2] = tc4;  assign o_wrap[2] = wrap4;  assign o_lerr[2] = lerr4;

  // Reference model: counts kept as plain decimal integers.
  int          nd [3] = '{2, 3, 4};
  int          md [3] = '{100, 1000, 10000};
  int          m_cnt  [3];
  logic [27:0] m_hex  [3];
  logic        m_wrap [3];
  logic        m_lerr [3];
  logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int to_int(logic [31:0] b, int n);
    int v = 0;
    for (int k = n - 1; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(int v, int n);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit valid_bcd(logic [31:0] b, int n);
    for (int k = 0; k < n; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [27:0] hex_of(int v, int n);
    logic [27:0] r = 28'h0;
    for (int k = 0; k < n; k++) begin
      r[7*k +: 7] = seg_tbl[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic exp_tc(int i);
    return En && !Load && !Clr &&
           ((Up && m_cnt[i] == md[i] - 1) || (!Up && m_cnt[i] == 0));
  endfunction

  // Advance one clock edge and the reference model together.
  task automatic tick();
    int          nc [3];
    logic [27:0] nh [3];
    logic        nw [3];
    logic        nl [3];
    for (int i = 0; i < 3; i++) begin
      nc[i] = m_cnt[i];
      nw[i] = 1'b0;
      nl[i] = 1'b0;
      nh[i] = hex_of(Clr ? 0 : m_cnt[i], nd[i]);
      if (Clr) begin
        nc[i] = 0;
      end else if (Load) begin
        if (valid_bcd(LoadVal, nd[i])) nc[i] = to_int(LoadVal, nd[i]);
        else nl[i] = 1'b1;
      end else if (En) begin
        if (Up) begin
          nw[i] = (m_cnt[i] == md[i] - 1);
          nc[i] = (m_cnt[i] + 1) % md[i];
        end else begin
          nw[i] = (m_cnt[i] == 0);
          nc[i] = (m_cnt[i] + md[i] - 1) % md[i];
        end
      end
    end
    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = nc[i]; m_hex[i] = nh[i]; m_wrap[i] = nw[i]; m_lerr[i] = nl[i];
    end
    #1;
  endtask

  task automatic test_reset();
    Clr = 1'b1; En = 1'b1; Up = 1'b1; Load = 1'b1; LoadVal = 32'h12345678;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_tc[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_tc[%0d]: got %b want 0", i, o_tc[i]);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_cnt[i] !== 32'h0 || o_hex[i] !== hex_of(0, nd[i]) ||
          o_wrap[i] !== 1'b0 || o_lerr[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: cnt=%0h hex=%0h wrap=%b lerr=%b want 0/%0h/0/0",
                 i, o_cnt[i], o_hex[i], o_wrap[i], o_lerr[i], hex_of(0, nd[i]));
      end
    end
    Clr = 1'b0; Load = 1'b0; En = 1'b0;
  endtask

  task automatic test_count_up_wrap();
    int wraps = 0;
    Clr = 1'b1; En = 1'b0; tick();
    Clr = 1'b0; En = 1'b1; Up = 1'b1;
    for (int j = 1; j <= 100; j++) begin
      #1;
      n_checks++;
      if (tc2 !== (j == 100)) begin
        n_fail++; $display("FAIL up_tc edge %0d: got %b want %b", j, tc2, (j == 100));
      end
      tick();
      if (wrap2) wraps++;
      n_checks++;
      if (o_cnt[0] !== to_bcd(j % 100, 2) || wrap2 !== (j == 100) ||
          o_hex[0] !== hex_of(j - 1, 2)) begin
        n_fail++;
        $display("FAIL up_seq edge %0d: cnt=%0h wrap=%b hex=%0h want %0h/%b/%0h", j,
                 o_cnt[0], wrap2, o_hex[0], to_bcd(j % 100, 2), (j == 100), hex_of(j - 1, 2));
      end
    end
    n_checks++;
    if (wraps != 1) begin
      n_fail++; $display("FAIL up_wrap_count: got %0d want 1", wraps);
    end
  endtask

  task automatic test_count_down();
    En = 1'b0; Load = 1'b1; LoadVal = 32'h10; tick();
    Load = 1'b0; En = 1'b1; Up = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      #1;
      n_checks++;
      if (tc2 !== (j == 11)) begin
        n_fail++; $display("FAIL down_tc edge %0d: got %b want %b", j, tc2, (j == 11));
      end
      tick();
      n_checks++;
      if (o_cnt[0] !== to_bcd((110 - j) % 100, 2) || wrap2 !== (j == 11)) begin
        n_fail++;
        $display("FAIL down_seq edge %0d: cnt=%0h wrap=%b want %0h/%b", j, o_cnt[0], wrap2,
                 to_bcd((110 - j) % 100, 2), (j == 11));
      end
    end
    n_checks++;
    if (o_cnt[1] !== 32'h999 || o_cnt[2] !== 32'h9999) begin
      n_fail++; $display("FAIL down_wide: got %0h/%0h want 999/9999", o_cnt[1], o_cnt[2]);
    end
    En = 1'b0;
  endtask

  task automatic test_load();
    En = 1'b0; Load = 1'b1; LoadVal = 32'h47; tick();
    n_checks++;
    if (cnt2 !== 8'h47 || lerr2 !== 1'b0) begin
      n_fail++; $display("FAIL load_ok: cnt=%0h lerr=%b want 47/0", cnt2, lerr2);
    end
    Load = 1'b0; tick();
    n_checks++;
    if (hex2 !== {7'h19, 7'h78}) begin
      n_fail++; $display("FAIL load_hex: got %0h want %0h", hex2, {7'h19, 7'h78});
    end
    Load = 1'b1; LoadVal = 32'h4A; tick();
    n_checks++;
    if (cnt2 !== 8'h47 || lerr2 !== 1'b1 || lerr4 !== 1'b1 || wrap2 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_bad: cnt=%0h lerr2=%b lerr4=%b wrap=%b want 47/1/1/0",
               cnt2, lerr2, lerr4, wrap2);
    end
    Load = 1'b0; tick();
    n_checks++;
    if (lerr2 !== 1'b0 || cnt2 !== 8'h47) begin
      n_fail++; $display("FAIL load_err_pulse: lerr=%b cnt=%0h want 0/47", lerr2, cnt2);
    end
    // Digit 3 invalid: only the 4-digit instance rejects it.
    Load = 1'b1; LoadVal = 32'hA055; tick();
    n_checks++;
    if (cnt2 !== 8'h55 || lerr2 !== 1'b0 || cnt4 !== 16'h0047 || lerr4 !== 1'b1) begin
      n_fail++;
      $display("FAIL load_partial: cnt2=%0h lerr2=%b cnt4=%0h lerr4=%b want 55/0/0047/1",
               cnt2, lerr2, cnt4, lerr4);
    end
    Load = 1'b0;
  endtask

  task automatic test_load_at_wrap();
    En = 1'b0; Load = 1'b1; LoadVal = 32'h9999; tick();
    En = 1'b1; Up = 1'b1; LoadVal = 32'h0123;
    #1;
    n_checks++;
    if (tc3 !== 1'b0) begin
      n_fail++; $display("FAIL loadwrap_tc: got %b want 0", tc3);
    end
    tick();
    n_checks++;
    if (cnt3 !== 12'h123 || wrap3 !== 1'b0 || wrap2 !== 1'b0 || cnt2 !== 8'h23) begin
      n_fail++;
      $display("FAIL loadwrap: cnt3=%0h wrap3=%b cnt2=%0h wrap2=%b want 123/0/23/0",
               cnt3, wrap3, cnt2, wrap2);
    end
    Load = 1'b0; En = 1'b0;
  endtask

  task automatic test_clr_override();
    Load = 1'b1; LoadVal = 32'h58; tick();
    Load = 1'b0; En = 1'b1; Up = 1'b1; Clr = 1'b1;
    tick();
    n_checks++;
    if (cnt2 !== 8'h00 || hex2 !== {7'h40, 7'h40} || wrap2 !== 1'b0) begin
      n_fail++; $display("FAIL clr_mid: cnt=%0h hex=%0h wrap=%b want 0/2040/0", cnt2, hex2, wrap2);
    end
    Clr = 1'b0; tick();
    n_checks++;
    if (cnt2 !== 8'h01) begin
      n_fail++; $display("FAIL clr_resume: got %0h want 01", cnt2);
    end
    En = 1'b0; Load = 1'b1; LoadVal = 32'h9999; tick();
    Clr = 1'b1; En = 1'b1; Up = 1'b1; Load = 1'b1; LoadVal = 32'hFFFF; tick();
    Clr = 1'b0; En = 1'b0; Load = 1'b0;
    n_checks++;
    if (cnt2 !== 8'h00 || wrap2 !== 1'b0 || lerr2 !== 1'b0 || lerr4 !== 1'b0) begin
      n_fail++; $display("FAIL clr_all: cnt=%0h wrap=%b lerr=%b want 0/0/0", cnt2, wrap2, lerr2);
    end
    tick();
    n_checks++;
    if (wrap2 !== 1'b0 || lerr2 !== 1'b0 || cnt2 !== 8'h00) begin
      n_fail++; $display("FAIL clr_after: wrap=%b lerr=%b cnt=%0h want 0/0/0", wrap2, lerr2, cnt2);
    end
  endtask

  task automatic test_up_toggle();
    En = 1'b0; Load = 1'b1; LoadVal = 32'h0999; tick();
    Load = 1'b0; En = 1'b1;
    for (int j = 0; j < 8; j++) begin
      Up = (j % 2 == 0);
      tick();
      n_checks++;
      if (cnt4 !== (Up ? 16'h1000 : 16'h0999) || wrap4 !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle edge %0d: cnt=%0h wrap=%b want %0h/0", j, cnt4, wrap4,
                 (Up ? 16'h1000 : 16'h0999));
      end
    end
    En = 1'b0;
  endtask

  task automatic test_random();
    bit mode = 1'b1;
    int sel;
    for (int c = 0; c < 400; c++) begin
      if (c % 40 == 0) mode = ~mode;
      Clr  = ($urandom_range(0, 24) == 0);
      Load = ($urandom_range(0, 7) == 0);
      En   = ($urandom_range(0, 4) != 0);
      Up   = ($urandom_range(0, 4) == 0) ? 1'($urandom) : mode;
      sel  = $urandom_range(0, 5);
      case (sel)
        0:       LoadVal = $urandom;
        1:       LoadVal = 32'h99999999;
        2:       LoadVal = 32'h0;
        default: LoadVal = to_bcd($urandom_range(0, 99999999), 8);
      endcase
      #1;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (o_tc[i] !== exp_tc(i)) begin
          n_fail++; $display("FAIL rnd_tc[%0d] cyc %0d: got %b want %b", i, c, o_tc[i], exp_tc(i));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (o_cnt[i] !== to_bcd(m_cnt[i], nd[i]) || o_hex[i] !== m_hex[i] ||
            o_wrap[i] !== m_wrap[i] || o_lerr[i] !== m_lerr[i]) begin
          n_fail++;
          $display("FAIL rnd_state[%0d] cyc %0d: cnt=%0h hex=%0h wrap=%b lerr=%b want %0h/%0h/%b/%b",
                   i, c, o_cnt[i], o_hex[i], o_wrap[i], o_lerr[i],
                   to_bcd(m_cnt[i], nd[i]), m_hex[i], m_wrap[i], m_lerr[i]);
        end
        n_checks++;
        if (o_wrap[i] === 1'b1 && o_lerr[i] === 1'b1) begin
          n_fail++; $display("FAIL rnd_excl[%0d] cyc %0d: wrap=1 lerr=1 want not both", i, c);
        end
      end
    end
    Clr = 1'b0; Load = 1'b0; En = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_hex[i] = 28'h0; m_wrap[i] = 1'b0; m_lerr[i] = 1'b0;
    end
    test_reset();
    test_count_up_wrap();
    test_count_down();
    test_load();
    test_load_at_wrap();
    test_clr_override();
    test_up_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
